// File: rtl/fp32_mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one external FP32 multiplier between
// NUM_REQ requesters, with a per-operation timeout on a hung multiplier.
module fp32_mul_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 15,
    localparam int unsigned GID_W  = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic [32*NUM_REQ-1:0]  req_a_i,
    input  logic [32*NUM_REQ-1:0]  req_b_i,
    output logic [NUM_REQ-1:0]     rsp_valid_o,
    input  logic [NUM_REQ-1:0]     rsp_ready_i,
    output logic [31:0]            rsp_result_o,
    output logic [31:0]            mul_a_o,
    output logic [31:0]            mul_b_o,
    output logic                   mul_start_o,
    input  logic [31:0]            mul_result_i,
    input  logic                   mul_done_i,
    output logic                   busy_o,
    output logic [GID_W-1:0]       grant_id_o,
    output logic                   err_timeout_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [31:0] QNAN  = 32'h7FC0_0000;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    state_e               state_q, state_d;
    logic [GID_W-1:0]     last_q, last_d;
    logic [GID_W-1:0]     grant_q, grant_d;
    logic [31:0]          opa_q, opa_d;
    logic [31:0]          opb_q, opb_d;
    logic [31:0]          res_q, res_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 start_q, start_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;

    logic [GID_W-1:0]     winner_c;
    logic                 found_c;
    logic [31:0]          idx_c;
    logic [31:0]          a_arr [NUM_REQ];
    logic [31:0]          b_arr [NUM_REQ];

    function automatic logic [NUM_REQ-1:0] onehot(input logic [GID_W-1:0] i);
        return NUM_REQ'(1) << i;
    endfunction

    // Unpack the flat operand buses into per-requester words
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign a_arr[g] = req_a_i[32*g +: 32];
        assign b_arr[g] = req_b_i[32*g +: 32];
    end

    // Round-robin search starting just after the last served requester
    always_comb begin
        winner_c = '0;
        found_c  = 1'b0;
        idx_c    = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx_c = (32'(last_q) + k) % NUM_REQ;
            if (!found_c && req_valid_i[GID_W'(idx_c)]) begin
                found_c  = 1'b1;
                winner_c = GID_W'(idx_c);
            end
        end
    end

    // Next-state and datapath updates for the sequencer
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        grant_d     = grant_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        res_d       = res_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        start_d     = 1'b0;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            S_IDLE: begin
                if (found_c) begin
                    opa_d   = a_arr[winner_c];
                    opb_d   = b_arr[winner_c];
                    grant_d = winner_c;
                    start_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // a completion on the expiry cycle still counts as success
                if (mul_done_i) begin
                    res_d       = mul_result_i;
                    rsp_valid_d = onehot(grant_q);
                    state_d     = S_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    res_d       = QNAN;
                    err_d       = 1'b1;
                    rsp_valid_d = onehot(grant_q);
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready_i[grant_q]) begin
                    last_d      = grant_q;
                    rsp_valid_d = '0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            last_q      <= GID_W'(NUM_REQ - 1);
            grant_q     <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            start_q     <= 1'b0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            res_q       <= res_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            start_q     <= start_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Accept is combinational so the winner is taken on the same edge
    assign req_ready_o   = (state_q == S_IDLE && found_c && !reset) ? onehot(winner_c) : '0;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_result_o  = res_q;
    assign mul_a_o       = opa_q;
    assign mul_b_o       = opb_q;
    assign mul_start_o   = start_q;
    assign busy_o        = (state_q != S_IDLE);
    assign grant_id_o    = grant_q;
    assign err_timeout_o = err_q;

endmodule

// File: tb/tb_fp32_mul_arbiter.sv
// Randomised scoreboard bench for fp32_mul_arbiter with a multiplier stub.
module tb_fp32_mul_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned TIMEOUT = 15;
    localparam int unsigned GID_W   = 2;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [NUM_REQ-1:0]    rsp_ready = '0;
    logic [31:0]           rsp_result, mul_a, mul_b, mul_result;
    logic                  mul_start, mul_done, busy, err_timeout;
    logic [GID_W-1:0]      grant_id;
    logic [31:0]           op_a [NUM_REQ];
    logic [31:0]           op_b [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
        assign req_a[32*g +: 32] = op_a[g];
        assign req_b[32*g +: 32] = op_b[g];
    end

    fp32_mul_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_a_i(req_a), .req_b_i(req_b),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
        .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_start_o(mul_start),
        .mul_result_i(mul_result), .mul_done_i(mul_done),
        .busy_o(busy), .grant_id_o(grant_id), .err_timeout_o(err_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Truncating FP32 product for normal operands; zero-exponent operands give signed zero
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          e;
        logic [47:0] p;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) return {s, 8'(e + 1), p[46:24]};
        return {s, 8'(e), p[45:23]};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        r[31]    = 1'($urandom_range(0, 1));
        r[30:23] = 8'($urandom_range(100, 150));
        r[22:0]  = 23'($urandom);
        if ($urandom_range(0, 9) == 0) r[30:23] = 8'd0;
        return r;
    endfunction

    // Multiplier stub: done pulses stub_lat cycles after start (0 = never)
    int          stub_lat = 3;
    int          st_cnt;
    logic [31:0] st_a, st_b;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            st_cnt     <= 0;
            mul_done   <= 1'b0;
            mul_result <= '0;
        end else begin
            mul_done <= 1'b0;
            if (mul_start) begin
                st_cnt <= (stub_lat == 0) ? 0 : stub_lat - 1;
                st_a   <= mul_a;
                st_b   <= mul_b;
            end else if (st_cnt == 1) begin
                mul_done   <= 1'b1;
                mul_result <= fmul(st_a, st_b);
                st_cnt     <= 0;
            end else if (st_cnt > 1) begin
                st_cnt <= st_cnt - 1;
            end
        end
    end

    typedef struct {
        int          id;
        logic [31:0] res;
        int          cyc;
        int          lat;
        bit          err;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] opq [NUM_REQ][$];
    int          log_id[$];
    logic [31:0] log_res[$];
    int          m_last    = NUM_REQ - 1;
    bit          m_err     = 1'b0;
    bit          start_exp = 1'b0;
    int          fixed_lat = 3;
    bit          rand_lat  = 1'b0;
    int          rdy_mode  = 0;

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < NUM_REQ; i++) n += opq[i].size();
        return n;
    endfunction

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i] = (opq[i].size() != 0);
            op_a[i]      = (opq[i].size() != 0) ? opq[i][0][63:32] : 32'd0;
            op_b[i]      = (opq[i].size() != 0) ? opq[i][0][31:0]  : 32'd0;
        end
        case (rdy_mode)
            0:       rsp_ready = '1;
            1:       rsp_ready = NUM_REQ'($urandom);
            default: rsp_ready = '0;
        endcase
    endtask

    // One clock of stimulus: observe accepts at negedge, push expectations, redrive after the edge
    task automatic step();
        logic [NUM_REQ-1:0] acc;
        logic [NUM_REQ-1:0] exp_acc;
        int                 w, j, lat;
        bit                 tmo;
        @(negedge clk);
        if (!reset) begin
            check(mul_start == start_exp, "mul_start", 32'(mul_start), 32'(start_exp));
            acc       = req_valid & req_ready;
            start_exp = (acc != 0);
            if (acc != 0) begin
                w = -1;
                for (int k = 1; k <= NUM_REQ; k++) begin
                    j = (m_last + k) % NUM_REQ;
                    if (w < 0 && req_valid[j]) w = j;
                end
                exp_acc = NUM_REQ'(1) << w;
                check(acc == exp_acc, "grant", 32'(acc), 32'(exp_acc));
                if (rand_lat) begin
                    lat = $urandom_range(1, 17);
                    if (lat == 1) lat = 0;
                end else begin
                    lat = fixed_lat;
                end
                stub_lat = lat;
                tmo      = (lat == 0 || lat > int'(TIMEOUT));
                m_err    = m_err | tmo;
                sb.push_back('{w, tmo ? QNAN : fmul(opq[w][0][63:32], opq[w][0][31:0]),
                               cyc, tmo ? int'(TIMEOUT) + 2 : lat + 2, m_err});
                void'(opq[w].pop_front());
                m_last = w;
            end
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (pending() == 0 && sb.size() == 0 && !busy && !start_exp) return;
            step();
        end
        check(1'b0, "drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic zero_checks();
        check(req_ready == 0,   "rst_req_ready",  32'(req_ready), 32'd0);
        check(rsp_valid == 0,   "rst_rsp_valid",  32'(rsp_valid), 32'd0);
        check(rsp_result == 0,  "rst_rsp_result", rsp_result, 32'd0);
        check((mul_a | mul_b) == 0, "rst_mul_ops", mul_a | mul_b, 32'd0);
        check(!mul_start,       "rst_mul_start",  32'(mul_start), 32'd0);
        check(!busy,            "rst_busy",       32'(busy), 32'd0);
        check(grant_id == 0,    "rst_grant_id",   32'(grant_id), 32'd0);
        check(!err_timeout,     "rst_err",        32'(err_timeout), 32'd0);
    endtask

    task automatic model_reset();
        sb.delete();
        for (int i = 0; i < NUM_REQ; i++) opq[i].delete();
        m_last    = NUM_REQ - 1;
        m_err     = 1'b0;
        start_exp = 1'b0;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        #1;
        zero_checks();
        model_reset();
        drive();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: compare each response against the head of the scoreboard
    initial begin : monitor
        bit          prev;
        exp_t        e;
        int          act_id;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev = 1'b0;
                continue;
            end
            if (rsp_valid != 0) begin
                check(req_ready == 0, "ready_and_valid", 32'(req_ready), 32'd0);
                act_id = -1;
                for (int i = 0; i < NUM_REQ; i++) if (rsp_valid[i]) act_id = i;
                if (!prev) begin
                    if (sb.size() == 0) begin
                        check(1'b0, "unexpected_rsp", 32'(rsp_valid), 32'd0);
                    end else begin
                        e = sb[0];
                        check(rsp_valid == NUM_REQ'(1) << e.id, "rsp_owner", 32'(rsp_valid), 32'(1) << e.id);
                        check(grant_id == GID_W'(e.id), "grant_id", 32'(grant_id), 32'(e.id));
                        check(rsp_result == e.res, "rsp_result", rsp_result, e.res);
                        check(cyc - e.cyc == e.lat, "latency", 32'(cyc - e.cyc), 32'(e.lat));
                        check(err_timeout == e.err, "err_timeout", 32'(err_timeout), 32'(e.err));
                    end
                end
                if ((rsp_valid & rsp_ready) != 0 && sb.size() != 0) begin
                    void'(sb.pop_front());
                    log_id.push_back(act_id);
                    log_res.push_back(rsp_result);
                end
            end
            prev = (rsp_valid != 0);
        end
    end

    initial begin : main
        logic [NUM_REQ-1:0] rv;
        logic [31:0]        rres;
        int                 issued;
        int                 exp_ids[4];
        logic [31:0]        exp_res[4];

        // Power-on reset with requester 1 already requesting
        drive();
        #1;
        reset = 1'b1;
        opq[1].push_back({32'h4000_0000, 32'h4040_0000});
        drive();
        #1;
        zero_checks();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Single operation 2.0 x 3.0 on requester 1
        drain(100);
        check(log_id.size() == 1 && log_id[0] == 1, "t1_owner", 32'(log_id.size() ? log_id[0] : -1), 32'd1);
        check(log_res.size() == 1 && log_res[0] == 32'h40C0_0000, "t1_result",
              log_res.size() ? log_res[0] : 32'hDEAD_BEEF, 32'h40C0_0000);

        // All four at once after reset: served 0,1,2,3
        reset_pulse();
        log_id.delete(); log_res.delete();
        opq[0].push_back({32'h3FC0_0000, 32'h4000_0000});
        opq[1].push_back({32'h4000_0000, 32'h4000_0000});
        opq[2].push_back({32'hBF80_0000, 32'h4080_0000});
        opq[3].push_back({32'h0000_0000, 32'h40E0_0000});
        drive();
        drain(200);
        exp_res = '{32'h4040_0000, 32'h4080_0000, 32'hC080_0000, 32'h0000_0000};
        check(log_id.size() == 4, "t2_count", 32'(log_id.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_id.size(); i++) begin
            check(log_id[i] == i, "t2_order", 32'(log_id[i]), 32'(i));
            check(log_res[i] == exp_res[i], "t2_result", log_res[i], exp_res[i]);
        end

        // Two persistent requesters alternate
        log_id.delete(); log_res.delete();
        for (int i = 0; i < 3; i++) begin
            opq[0].push_back({rand_fp(), rand_fp()});
            opq[2].push_back({rand_fp(), rand_fp()});
        end
        drive();
        drain(300);
        exp_ids = '{0, 2, 0, 2};
        check(log_id.size() == 6, "t3_count", 32'(log_id.size()), 32'd6);
        for (int i = 0; i < log_id.size(); i++)
            check(log_id[i] == exp_ids[i % 4], "t3_order", 32'(log_id[i]), 32'(exp_ids[i % 4]));

        // Response back-pressure holds everything in RESP
        rdy_mode = 2;
        opq[1].push_back({rand_fp(), rand_fp()});
        opq[3].push_back({rand_fp(), rand_fp()});
        drive();
        for (int i = 0; i < 50 && rsp_valid == 0; i++) step();
        check(rsp_valid != 0, "t4_reach_resp", 32'(rsp_valid), 32'd2);
        rv   = rsp_valid;
        rres = rsp_result;
        for (int i = 0; i < 10; i++) begin
            step();
            check(rsp_valid == rv, "t4_hold_valid", 32'(rsp_valid), 32'(rv));
            check(rsp_result == rres, "t4_hold_result", rsp_result, rres);
            check(busy && req_ready == 0 && !mul_start, "t4_hold_ctrl",
                  {29'd0, busy, |req_ready, mul_start}, 32'h4);
        end
        rdy_mode  = 0;
        rsp_ready = '1;
        step();
        check(!busy && rsp_valid == 0, "t4_release", {31'd0, busy}, 32'd0);
        drain(200);

        // Done on the very last WAIT cycle wins over the timeout
        fixed_lat = int'(TIMEOUT);
        opq[0].push_back({rand_fp(), rand_fp()});
        drive();
        drain(200);
        check(!err_timeout, "t5_edge_no_err", 32'(err_timeout), 32'd0);

        // Hung multiplier: qNaN and sticky error
        log_id.delete(); log_res.delete();
        fixed_lat = 0;
        opq[2].push_back({rand_fp(), rand_fp()});
        drive();
        drain(200);
        check(err_timeout, "t5_err_set", 32'(err_timeout), 32'd1);
        check(log_res.size() == 1 && log_res[0] == QNAN, "t5_qnan",
              log_res.size() ? log_res[0] : 32'hDEAD_BEEF, QNAN);
        log_id.delete(); log_res.delete();
        fixed_lat = 3;
        opq[1].push_back({32'h4000_0000, 32'h4040_0000});
        drive();
        drain(200);
        check(log_res.size() == 1 && log_res[0] == 32'h40C0_0000, "t5_after",
              log_res.size() ? log_res[0] : 32'hDEAD_BEEF, 32'h40C0_0000);
        check(err_timeout, "t5_err_sticky", 32'(err_timeout), 32'd1);

        // Reset during WAIT aborts silently; priority restarts from 0
        opq[2].push_back({rand_fp(), rand_fp()});
        drive();
        for (int i = 0; i < 20 && !busy; i++) step();
        step();
        check(busy && grant_id == 2, "t6_in_wait", 32'(grant_id), 32'd2);
        reset = 1'b1;
        #1;
        zero_checks();
        model_reset();
        log_id.delete(); log_res.delete();
        opq[2].push_back({rand_fp(), rand_fp()});
        opq[3].push_back({rand_fp(), rand_fp()});
        drive();
        repeat (2) @(posedge clk);
        #1;
        check(req_ready == 0 && rsp_valid == 0, "t6_gated", 32'(req_ready), 32'd0);
        reset = 1'b0;
        drain(200);
        check(log_id.size() == 2 && log_id[0] == 2 && log_id[1] == 3, "t6_order",
              32'(log_id.size() ? log_id[0] : -1), 32'd2);

        // Random traffic, random latencies and random back-pressure
        rand_lat = 1'b1;
        rdy_mode = 1;
        issued   = 0;
        for (int c = 0; c < 4000 && issued < 60; c++) begin
            step();
            if ($urandom_range(0, 2) == 0) begin
                opq[$urandom_range(0, NUM_REQ - 1)].push_back({rand_fp(), rand_fp()});
                issued++;
            end
        end
        drain(4000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
